// File: rtl/path_stack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | path_stack: LIFO of 8-bit maze locations with a bottom-to-top replay.    |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module path_stack #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    dataIn,
  input  logic          run,
  output logic [7:0]    top,
  output logic          empStck,
  output logic          full,
  output logic [AW:0]   count,
  output logic          replayValid,
  output logic [7:0]    replayLoc,
  output logic          replayDone,
  output logic          busy,
  output logic          ovf,
  output logic          udf
);

  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_REPLAY = 2'd1;
  localparam logic [1:0]    S_FINISH = 2'd2;
  localparam logic [AW:0]   c_depth  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_one    = (AW+1)'(1);
  localparam logic [AW-1:0] c_ione   = AW'(1);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] ri_q, ri_d;
  logic [AW:0]   rl_q, rl_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [7:0]    mem_q [DEPTH];

  logic          we;
  logic [AW-1:0] wr_addr;
  logic          is_empty;
  logic          is_full;
  logic [AW-1:0] top_idx;
  logic          ri_last;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == c_depth);
  // At sp==DEPTH the low bits wrap to 0, so the subtraction still lands on DEPTH-1.
  assign top_idx  = sp_q[AW-1:0] - c_ione;
  assign ri_last  = ({1'b0, ri_q} == (rl_q - c_one));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (run) state_d = is_empty ? S_FINISH : S_REPLAY;
        S_REPLAY: if (ri_last) state_d = S_FINISH;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    replayValid = (state_q == S_REPLAY);
    busy        = (state_q == S_REPLAY);
    replayDone  = (state_q == S_FINISH);
    replayLoc   = replayValid ? mem_q[ri_q] : 8'h00;
  end

  // Stack operations are only honoured in IDLE; a replay freezes sp and flags.
  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    ri_d    = ri_q;
    rl_d    = rl_q;
    we      = 1'b0;
    wr_addr = sp_q[AW-1:0];
    if (clr) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
      ri_d  = '0;
    end else if (state_q == S_IDLE) begin
      if (push && pop && !is_empty) begin
        we      = 1'b1;
        wr_addr = top_idx;
      end else if (push) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + c_one;
        end
      end else if (pop) begin
        if (is_empty) udf_d = 1'b1;
        else          sp_d  = sp_q - c_one;
      end
      if (run) begin
        ri_d = '0;
        rl_d = sp_q;
      end
    end else if (state_q == S_REPLAY) begin
      ri_d = ri_q + c_ione;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ri_q  <= '0;
      rl_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ri_q  <= ri_d;
      rl_q  <= rl_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[wr_addr] <= dataIn;
  end

  assign top     = is_empty ? 8'h00 : mem_q[top_idx];
  assign empStck = is_empty;
  assign full    = is_full;
  assign count   = sp_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_path_stack.sv
`default_nettype none
// Directed self-checking bench for path_stack (DEPTH=64).
module tb_path_stack;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [7:0]    dataIn = 8'h00;
  logic          run = 1'b0;
  logic [7:0]    top;
  logic          empStck;
  logic          full;
  logic [AW:0]   count;
  logic          replayValid;
  logic [7:0]    replayLoc;
  logic          replayDone;
  logic          busy;
  logic          ovf;
  logic          udf;

  int n_checks = 0;
  int n_errors = 0;

  path_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .dataIn(dataIn), .run(run), .top(top), .empStck(empStck),
    .full(full), .count(count), .replayValid(replayValid),
    .replayLoc(replayLoc), .replayDone(replayDone), .busy(busy),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1; dataIn = d;
    tick();
    push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_top"},   32'(top), 32'h00);
    chk({tag, "_emp"},   32'(empStck), 32'd1);
    chk({tag, "_full"},  32'(full), 32'd0);
    chk({tag, "_cnt"},   32'(count), 32'd0);
    chk({tag, "_vld"},   32'(replayValid), 32'd0);
    chk({tag, "_loc"},   32'(replayLoc), 32'h00);
    chk({tag, "_done"},  32'(replayDone), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_ovf"},   32'(ovf), 32'd0);
    chk({tag, "_udf"},   32'(udf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] path [4];
    path[0] = 8'h00; path[1] = 8'h01; path[2] = 8'h11; path[3] = 8'hFF;

    tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Basic push / pop
    do_push(8'h00); do_push(8'h01); do_push(8'h11);
    chk("push3_cnt", 32'(count), 32'd3);
    chk("push3_top", 32'(top), 32'h11);
    do_pop();
    chk("pop_cnt", 32'(count), 32'd2);
    chk("pop_top", 32'(top), 32'h01);
    chk("pop_emp", 32'(empStck), 32'd0);

    // Simultaneous push+pop replaces the top
    push = 1'b1; pop = 1'b1; dataIn = 8'h12;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("repl_top", 32'(top), 32'h12);
    chk("repl_cnt", 32'(count), 32'd2);

    do_clr();
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_emp", 32'(empStck), 32'd1);

    // Run on an empty stack: straight to the done pulse
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("erun_done", 32'(replayDone), 32'd1);
    chk("erun_vld", 32'(replayValid), 32'd0);
    chk("erun_busy", 32'(busy), 32'd0);
    tick();
    chk("erun_done2", 32'(replayDone), 32'd0);
    chk("erun_vld2", 32'(replayValid), 32'd0);

    // Replay of a 4-entry path, with push/pop attempts that must be ignored
    for (int i = 0; i < 4; i++) do_push(path[i]);
    run = 1'b1;
    tick();
    run = 1'b0;
    push = 1'b1; dataIn = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rp_vld%0d", i), 32'(replayValid), 32'd1);
      chk($sformatf("rp_loc%0d", i), 32'(replayLoc), 32'(path[i]));
      chk($sformatf("rp_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("rp_cnt%0d", i), 32'(count), 32'd4);
      tick();
    end
    chk("rp_done", 32'(replayDone), 32'd1);
    chk("rp_vldf", 32'(replayValid), 32'd0);
    chk("rp_locf", 32'(replayLoc), 32'h00);
    chk("rp_busyf", 32'(busy), 32'd0);
    push = 1'b0;
    tick();
    chk("rp_done2", 32'(replayDone), 32'd0);
    chk("rp_cnt_after", 32'(count), 32'd4);
    chk("rp_top_after", 32'(top), 32'hFF);
    chk("rp_ovf", 32'(ovf), 32'd0);

    // Fill to full, overflow, then drain past empty
    do_clr();
    for (int i = 0; i < DEPTH; i++) do_push(8'(i + 1));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_cnt", 32'(count), 32'(DEPTH));
    chk("fill_ovf0", 32'(ovf), 32'd0);
    do_push(8'hEE);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_cnt", 32'(count), 32'(DEPTH));
    chk("ovf_top", 32'(top), 32'h40);
    for (int i = 0; i < DEPTH; i++) do_pop();
    chk("drain_emp", 32'(empStck), 32'd1);
    chk("drain_top", 32'(top), 32'h00);
    chk("drain_udf0", 32'(udf), 32'd0);
    do_pop();
    chk("udf_flag", 32'(udf), 32'd1);
    chk("udf_emp", 32'(empStck), 32'd1);
    chk("udf_cnt", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    do_clr();
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_udf", 32'(udf), 32'd0);

    // Push+pop on empty is a plain push
    push = 1'b1; pop = 1'b1; dataIn = 8'h55;
    tick();
    push = 1'b0; pop = 1'b0;
    chk("pp0_cnt", 32'(count), 32'd1);
    chk("pp0_top", 32'(top), 32'h55);
    chk("pp0_udf", 32'(udf), 32'd0);

    // Reset on the second replay cycle
    do_clr();
    for (int i = 0; i < 4; i++) do_push(path[i]);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    chk("mid_loc", 32'(replayLoc), 32'h01);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst = 1'b0;
    do_push(8'h33);
    chk("post_top", 32'(top), 32'h33);
    chk("post_cnt", 32'(count), 32'd1);
    chk("post_vld", 32'(replayValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/path_stack.md
PATH_STACK -- requirements
Module: path_stack

Interface
REQ-001 Parameter DEPTH, default 64: number of 8-bit location entries; power of two.
REQ-002 Parameter AW, default 6: pointer width, equal to log2(DEPTH).
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port clr  input  1  synchronous clear: empties the stack and clears the error flags.
REQ-006 Port push  input  1  push dataIn onto the stack (controller move forward).
REQ-007 Port pop  input  1  remove the top entry (controller backtrack).
REQ-008 Port dataIn  input  8  location to push, {row[3:0], col[3:0]}.
REQ-009 Port run  input  1  one-cycle request to replay the stored path from bottom to top.
REQ-010 Port top  output  8  current top entry; 8'h00 when the stack is empty.
REQ-011 Port empStck  output  1  high when the stack holds 0 entries.
REQ-012 Port full  output  1  high when the stack holds DEPTH entries.
REQ-013 Port count  output  AW+1  number of stored entries.
REQ-014 Port replayValid  output  1  replayLoc is valid this cycle.
REQ-015 Port replayLoc  output  8  replayed location; 8'h00 when replayValid is low.
REQ-016 Port replayDone  output  1  one-cycle pulse when a replay completes.
REQ-017 Port busy  output  1  high while a replay is in progress.
REQ-018 Port ovf  output  1  sticky flag: a push was attempted while the stack was full.
REQ-019 Port udf  output  1  sticky flag: a pop was attempted while the stack was empty.

Function
REQ-020 Storage is DEPTH x 8 registers addressed by the stack pointer sp (0..DEPTH); entry i is stored at index i, with the bottom at index 0.
REQ-021 top and empStck are combinational from sp and storage: top = mem[sp-1] when sp>0.
REQ-022 In IDLE, push only (sp<DEPTH): write mem[sp] <= dataIn and sp <= sp+1.
REQ-023 In IDLE, pop only (sp>0): sp <= sp-1; storage is left unchanged.
REQ-024 Push and pop in the same cycle with sp>0 replace the top entry: mem[sp-1] <= dataIn and sp is unchanged.
REQ-025 Push and pop in the same cycle with sp==0 act as a push only; udf is not set.
REQ-026 Push at full (without pop) is ignored and sets ovf; pop at empty (without push) is ignored and sets udf.
REQ-027 clr has priority over all other inputs except rst: sp <= 0, ovf <= 0, udf <= 0, FSM <= IDLE, and push/pop/run in that cycle are ignored.
REQ-028 The FSM has three states: IDLE, REPLAY and FINISH.
REQ-029 IDLE to REPLAY on run with sp>0: the replay index ri <= 0, the replay length rl <= sp, and busy <= 1.
REQ-030 IDLE to FINISH on run with sp==0; no replayValid is produced.
REQ-031 In REPLAY, each cycle drives replayValid=1 and replayLoc=mem[ri], then ri <= ri+1; after ri==rl-1 the FSM goes to FINISH.
REQ-032 FINISH drives replayDone=1 for exactly one cycle, busy=0 and next state IDLE.
REQ-033 Latency: the first replayValid occurs the cycle after run is sampled; a path of N entries gives N consecutive valid cycles, then the replayDone pulse.
REQ-034 While busy, and in FINISH, push, pop and run are ignored and the flags are not set; storage and sp are preserved by a replay.
REQ-035 full = (sp==DEPTH); count = sp; the pointer never wraps.

Reset
REQ-036 rst asserted at any time, including mid-replay, forces sp=0, FSM=IDLE, ri=0 and ovf=udf=0.
REQ-037 While rst is asserted, outputs are top=8'h00, empStck=1, full=0, count=0, replayValid=0, replayLoc=8'h00, replayDone=0 and busy=0.
REQ-038 Storage contents are not reset.

Verification
REQ-039 Push 8'h00, 8'h01 and 8'h11, then pop -> count=2, top=8'h01, empStck=0.
REQ-040 Push 8'h12 and pop in the same cycle with top=8'h01 -> top=8'h12, count unchanged.
REQ-041 Push DEPTH entries, then 1 extra -> full=1, ovf=1, count=DEPTH, top = last accepted value; pop 65 times -> udf=1, empStck=1.
REQ-042 Stack holds 00, 01, 11, FF; pulse run -> replayLoc sequence 00, 01, 11, FF on 4 consecutive valid cycles, then replayDone for 1 cycle; count stays at 4.
REQ-043 run with the stack empty -> replayDone the cycle after run; replayValid never asserts.
REQ-044 Assert rst on the 2nd replay cycle -> all outputs take the reset values of REQ-037 immediately; push 8'h33 after release -> top=8'h33, count=1.
